// File: rtl/mult_control.sv
// mult_control -- FSM sequencer for a shift-add multiplier datapath.
//
// Steps the external datapath (multiplicand register, multiplier/product
// shift register, adder) through one multiply of WIDTH iterations. Every
// iteration is a TEST (look at multiplier bit 0), an optional ADD, and a
// SHIFT. The product is held valid in DONE until the consumer acknowledges
// it. Start and Ack together in DONE begin the next multiply without an
// idle cycle in between.
//
// Parameters
//   WIDTH  operand width = iterations per multiply (>= 2)
//   CNT_W  iteration counter width, 2**CNT_W > WIDTH
//
// Ports
//   Clk    in   clock, all state on posedge
//   Rst_n  in   asynchronous active-low reset
//   Start  in   request a new multiply (honoured in IDLE, or in DONE with Ack)
//   Abort  in   synchronous cancel from any state back to IDLE, no Done
//   Ack    in   consumer took the product, releases DONE
//   Lsb    in   multiplier bit 0 from the datapath, looked at only in TEST
//   Load   out  load operands and clear the product upper half
//   Add    out  add multiplicand into the product upper half
//   Shift  out  shift product/multiplier right by one
//   Busy   out  high in LOAD/TEST/ADD/SHIFT
//   Done   out  product valid, high in DONE until Ack
//   Iter   out  iterations completed in the current operation
module mult_control #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Abort,
    input  logic             Ack,
    input  logic             Lsb,
    output logic             Load,
    output logic             Add,
    output logic             Shift,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] Iter
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] TEST  = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] SHIFT = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] iter_nxt;

    always_comb begin
        state_nxt = state;
        iter_nxt  = Iter;
        if (Abort) begin
            state_nxt = IDLE;
            iter_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) state_nxt = LOAD;
                end
                LOAD: begin
                    iter_nxt  = '0;
                    state_nxt = TEST;
                end
                TEST: begin
                    state_nxt = Lsb ? ADD : SHIFT;
                end
                ADD: begin
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    // Iter reaches WIDTH on the final shift and is held there
                    // through DONE; the test uses the pre-increment value.
                    iter_nxt  = Iter + CNT_W'(1);
                    state_nxt = (Iter == LAST_ITER) ? DONE : TEST;
                end
                DONE: begin
                    if (Ack) state_nxt = Start ? LOAD : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    iter_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            Iter  <= '0;
        end else begin
            state <= state_nxt;
            Iter  <= iter_nxt;
        end
    end

    // Moore decodes: reset forces the state register to IDLE, so every
    // output drops in the same cycle reset is asserted.
    assign Load  = (state == LOAD);
    assign Add   = (state == ADD);
    assign Shift = (state == SHIFT);
    assign Done  = (state == DONE);
    assign Busy  = (state == LOAD) || (state == TEST) ||
                   (state == ADD)  || (state == SHIFT);

endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control -- scoreboard bench for mult_control (WIDTH=32).
//
// The stimulus pushes the expected result of each multiply (Done cycle,
// Add count, iterations at which Add fires) into a queue. A monitor running
// on the falling edge tallies strobes and pops/compares when Done rises.
// A small datapath model drives Lsb from the multiplier operand.
module tb_mult_control;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    logic             Clk   = 1'b0;
    logic             Rst_n = 1'b0;
    logic             Start = 1'b0;
    logic             Abort = 1'b0;
    logic             Ack   = 1'b0;
    logic             Lsb;
    logic             Load;
    logic             Add;
    logic             Shift;
    logic             Busy;
    logic             Done;
    logic [CNT_W-1:0] Iter;

    mult_control #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .Abort (Abort),
        .Ack   (Ack),
        .Lsb   (Lsb),
        .Load  (Load),
        .Add   (Add),
        .Shift (Shift),
        .Busy  (Busy),
        .Done  (Done),
        .Iter  (Iter)
    );

    always #5 Clk = ~Clk;

    int unsigned tests    = 0;
    int unsigned fails    = 0;
    int unsigned edge_cnt = 0;

    always @(posedge Clk) edge_cnt++;

    // Multiplier shift register of the datapath: loaded on Load, shifted on
    // Shift; updated mid-cycle so Lsb is stable at the next rising edge.
    logic [31:0] b_op = '0;
    logic [31:0] mreg = '0;
    assign Lsb = mreg[0];
    always @(negedge Clk) begin
        if (Load)       mreg = b_op;
        else if (Shift) mreg = mreg >> 1;
    end

    typedef struct {
        logic [31:0] b;
        int unsigned done_cyc;
        int unsigned adds;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int unsigned n_load, n_add, n_shift, load_edge;
    logic [31:0] add_mask;
    bit          prev_add, adj_bad, prev_done;
    exp_t        e;

    task automatic clear_tally();
        n_load   = 0;
        n_add    = 0;
        n_shift  = 0;
        add_mask = '0;
        adj_bad  = 1'b0;
        prev_add = 1'b0;
    endtask

    initial clear_tally();

    always @(negedge Clk) begin
        if (!Busy && !Done) begin
            clear_tally();
        end else begin
            check("strobe_onehot", 64'($countones({Load, Add, Shift, Done}) <= 1), 64'd1);
            if (prev_add && !Shift) adj_bad = 1'b1;
            prev_add = Add;
            if (Load) begin
                n_load++;
                load_edge = edge_cnt;
            end
            if (Add) begin
                n_add++;
                add_mask[Iter[4:0]] = 1'b1;
            end
            if (Shift) n_shift++;
            if (Done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(edge_cnt - load_edge + 1), 64'(e.done_cyc));
                    check("load_count", 64'(n_load), 64'd1);
                    check("add_count", 64'(n_add), 64'(e.adds));
                    check("shift_count", 64'(n_shift), 64'(WIDTH));
                    check("add_iters", 64'(add_mask), 64'(e.b));
                    check("add_before_shift", 64'(adj_bad), 64'd0);
                    check("iter_done", 64'(Iter), 64'(WIDTH));
                    check("busy_in_done", 64'(Busy), 64'd0);
                end
            end
            if (Done) clear_tally();
        end
        prev_done = Done;
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input string name);
        int unsigned n = 0;
        while (!Done && n < 300) begin
            @(negedge Clk);
            n++;
        end
        if (!Done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic issue(input logic [31:0] b, input int unsigned dc, input int unsigned adds);
        @(negedge Clk);
        b_op = b;
        exp_q.push_back('{b, dc, adds});
        Start = 1'b1;
        @(negedge Clk);   // cycle 1
        Start = 1'b0;
    endtask

    task automatic ack_idle();
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        check("ack_to_idle", 64'({Busy, Done}), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({Load, Add, Shift, Busy, Done, Iter}), 64'd0);
    endtask

    initial begin
        #2;
        check_all_zero("reset_state");
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_all_zero("idle_after_reset");

        // hand-computed: done = 2 + 2*32 + popcount(B)
        issue(32'h0000_0000, 66, 0);  wait_done("b_zero");  ack_idle();
        issue(32'hFFFF_FFFF, 98, 32); wait_done("b_ones");  ack_idle();
        issue(32'h0000_0005, 68, 2);  wait_done("b_five");  ack_idle();

        // Start re-pulsed while busy must be ignored
        issue(32'h1234_5678, 79, 13);
        repeat (4) @(negedge Clk);    // cycle 5
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (34) @(negedge Clk);   // cycle 40
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        wait_done("repulse");
        ack_idle();

        // Done held without Ack, then back-to-back Ack+Start
        issue(32'h0000_0003, 68, 2);
        wait_done("hold");
        repeat (10) @(negedge Clk);
        check("done_hold", 64'(Done), 64'd1);
        check("iter_hold", 64'(Iter), 64'(WIDTH));
        b_op = 32'h8000_0000;
        exp_q.push_back('{32'h8000_0000, 67, 1});
        Ack   = 1'b1;
        Start = 1'b1;
        @(negedge Clk);
        Ack   = 1'b0;
        Start = 1'b0;
        check("b2b_load", 64'({Load, Done}), 64'b10);
        wait_done("b2b");
        ack_idle();

        // asynchronous reset mid-operation
        issue(32'hFFFF_FFFF, 98, 32);
        repeat (19) @(negedge Clk);   // cycle 20
        exp_q.delete();
        Rst_n = 1'b0;
        #1;
        check_all_zero("reset_midop");
        repeat (2) @(negedge Clk);
        check_all_zero("reset_held");
        Rst_n = 1'b1;
        repeat (5) @(negedge Clk);
        check_all_zero("idle_after_midop_reset");

        // Abort at cycle 30 of a new op; Done must never appear
        issue(32'hFFFF_FFFF, 98, 32);
        repeat (29) @(negedge Clk);   // cycle 30
        exp_q.delete();
        Abort = 1'b1;
        @(negedge Clk);
        Abort = 1'b0;
        check("abort_idle", 64'({Busy, Done, Iter}), 64'd0);
        repeat (100) @(negedge Clk);
        check("abort_no_done", 64'({Busy, Done}), 64'd0);

        // Ack outside DONE is harmless, a fresh op still runs normally
        ack_idle();
        issue(32'h0000_0005, 68, 2);  wait_done("after_abort"); ack_idle();

        repeat (3) @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
